// File: rtl/ps_mem_access.sv
// Data-memory access stage: one req/gnt/rvalid bus transaction per load/store, with lane
// selection, load extension, bus timeout and pipeline stall. Optional: MEM_MISALIGN_CHK_EN.
module ps_mem_access #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic [2:0]  ex_mem_ren,
    input  logic [31:0] ex_mem_radd,
    input  logic [6:0]  ex_mem_rd_add,
    input  logic [2:0]  ex_mem_wen,
    input  logic [31:0] ex_mem_wadd,
    input  logic [31:0] ex_mem_wdata,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        mem_rd_en,
    output logic [6:0]  mem_rd_add,
    output logic [31:0] mem_rd_data,
    output logic        mem_pause,
    output logic        mem_err,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        err_q, err_d;
    logic [2:0]  type_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [6:0]  tag_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        ld_v, st_v, accept, tmo_hit;
    logic [1:0]  size;
    logic [31:0] a_raw, a_al;
    logic [3:0]  be_new;
    logic [31:0] s_rd, ext;

    // Request decode; a load beats a simultaneous store, unused encodings mean "none".
    always_comb begin
        ld_v  = (ex_mem_ren != 3'd0) && (ex_mem_ren <= 3'd5);
        st_v  = (ex_mem_wen != 3'd0) && (ex_mem_wen <= 3'd3);
        a_raw = ld_v ? ex_mem_radd : ex_mem_wadd;
        size  = SZ_W;
        if (ld_v) begin
            case (ex_mem_ren)
                3'd1, 3'd4: size = SZ_B;
                3'd2, 3'd5: size = SZ_H;
                default:    size = SZ_W;
            endcase
        end else begin
            case (ex_mem_wen)
                3'd1:    size = SZ_B;
                3'd2:    size = SZ_H;
                default: size = SZ_W;
            endcase
        end
        case (size)
            SZ_B:    a_al = a_raw;
            SZ_H:    a_al = {a_raw[31:1], 1'b0};
            default: a_al = {a_raw[31:2], 2'b00};
        endcase
        case (size)
            SZ_B:    be_new = 4'b0001 << a_al[1:0];
            SZ_H:    be_new = 4'b0011 << {a_al[1], 1'b0};
            default: be_new = 4'hF;
        endcase
        accept  = (state_q == S_IDLE) && !pause && (ld_v || st_v);
        tmo_hit = (cnt_q == TMO_LAST);
    end

    always_comb begin
        s_rd = dbus_rdata >> {addr_q[1:0], 3'b000};
        case (type_q)
            3'd1:    ext = {{24{s_rd[7]}}, s_rd[7:0]};
            3'd2:    ext = {{16{s_rd[15]}}, s_rd[15:0]};
            3'd4:    ext = {24'h0, s_rd[7:0]};
            3'd5:    ext = {16'h0, s_rd[15:0]};
            default: ext = s_rd;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = 16'd0;
                    state_d = S_REQ;
`ifdef MEM_MISALIGN_CHK_EN
                    if ((size == SZ_H && a_raw[0]) || (size == SZ_W && a_raw[1:0] != 2'b00)) begin
                        err_d     = 1'b1;
                        rd_data_d = 32'h0;
                        state_d   = ld_v ? S_RESP : S_IDLE;
                    end
`endif
                end
            end
            S_REQ, S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                // A response needs a grant first, either earlier (WAIT) or in this same cycle.
                if (dbus_rvalid && (state_q == S_WAIT || dbus_gnt)) begin
                    rd_data_d = we_q ? rd_data_q : ext;
                    state_d   = we_q ? S_IDLE : S_RESP;
                end else if (tmo_hit) begin
                    err_d     = 1'b1;
                    rd_data_d = we_q ? rd_data_q : 32'h0;
                    state_d   = we_q ? S_IDLE : S_RESP;
                end else if (state_q == S_REQ && dbus_gnt) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (!pause) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            rd_data_q <= 32'h0;
            err_q     <= 1'b0;
            type_q    <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            tag_q     <= 7'h0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
            if (accept) begin
                type_q  <= ld_v ? ex_mem_ren : ex_mem_wen;
                we_q    <= !ld_v;
                addr_q  <= a_al;
                tag_q   <= ex_mem_rd_add;
                wdata_q <= ex_mem_wdata;
                be_q    <= be_new;
            end
        end
    end

    assign dbus_req    = (state_q == S_REQ);
    assign dbus_we     = we_q;
    assign dbus_addr   = {addr_q[31:2], 2'b00};
    assign dbus_be     = be_q;
    assign dbus_wdata  = wdata_q;
    assign mem_rd_en   = (state_q == S_RESP) && !pause;
    assign mem_rd_add  = tag_q;
    assign mem_rd_data = rd_data_q;
    assign mem_pause   = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    assign mem_err     = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ps_mem_access.sv
// Directed bench for ps_mem_access: vector table of bus transactions plus hand-written
// sequences for pause, gnt/rvalid overlap, timeout, async reset and misalignment.
module tb_ps_mem_access;

    logic        clk;
    logic        reset;
    logic        pause;
    logic [2:0]  ex_mem_ren;
    logic [31:0] ex_mem_radd;
    logic [6:0]  ex_mem_rd_add;
    logic [2:0]  ex_mem_wen;
    logic [31:0] ex_mem_wadd;
    logic [31:0] ex_mem_wdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        mem_rd_en;
    logic [6:0]  mem_rd_add;
    logic [31:0] mem_rd_data;
    logic        mem_pause;
    logic        mem_err;
    logic [1:0]  dbg_state;

    ps_mem_access #(.TMO_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .ex_mem_ren(ex_mem_ren), .ex_mem_radd(ex_mem_radd), .ex_mem_rd_add(ex_mem_rd_add),
        .ex_mem_wen(ex_mem_wen), .ex_mem_wadd(ex_mem_wadd), .ex_mem_wdata(ex_mem_wdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .mem_rd_en(mem_rd_en), .mem_rd_add(mem_rd_add),
        .mem_rd_data(mem_rd_data), .mem_pause(mem_pause), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  ren;
        logic [31:0] radd;
        logic [6:0]  tag;
        logic [2:0]  wen;
        logic [31:0] wadd;
        logic [31:0] wdata;
        int          gnt_dly;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs[12];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_idle();
        ex_mem_ren    = 3'd0;
        ex_mem_radd   = 32'h0;
        ex_mem_rd_add = 7'h0;
        ex_mem_wen    = 3'd0;
        ex_mem_wadd   = 32'h0;
        ex_mem_wdata  = 32'h0;
    endtask

    // Checks the presented load result against the head of the scoreboard.
    task automatic expect_result(input string nm, input logic [6:0] tag);
        check({nm, "_rd_en"}, 32'(mem_rd_en), 32'd1);
        check({nm, "_rd_add"}, 32'(mem_rd_add), 32'(tag));
        if (exp_q.size() == 0) begin
            check({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            check({nm, "_rd_data"}, mem_rd_data, exp_q.pop_front());
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        pause         = 1'b0;
        ex_mem_ren    = v.ren;
        ex_mem_radd   = v.radd;
        ex_mem_rd_add = v.tag;
        ex_mem_wen    = v.wen;
        ex_mem_wadd   = v.wadd;
        ex_mem_wdata  = v.wdata;
        #1;
        check({nm, "_acc_pause"}, 32'(mem_pause), 32'd1);
        if (!v.exp_we) exp_q.push_back(v.exp_data);
        tick();
        drive_idle();
        #1;
        check({nm, "_req"}, 32'(dbus_req), 32'd1);
        check({nm, "_addr"}, dbus_addr, v.exp_addr);
        check({nm, "_be"}, 32'(dbus_be), 32'(v.exp_be));
        check({nm, "_we"}, 32'(dbus_we), 32'(v.exp_we));
        if (v.exp_we) check({nm, "_wdata"}, dbus_wdata, v.wdata);
        for (int i = 0; i < v.gnt_dly; i++) begin
            tick();
            check({nm, "_req_hold"}, 32'(dbus_req), 32'd1);
            check({nm, "_be_hold"}, 32'(dbus_be), 32'(v.exp_be));
            check({nm, "_pause_hold"}, 32'(mem_pause), 32'd1);
        end
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        check({nm, "_req_drop"}, 32'(dbus_req), 32'd0);
        check({nm, "_wait_pause"}, 32'(mem_pause), 32'd1);
        dbus_rvalid = 1'b1;
        dbus_rdata  = v.rdata;
        tick();
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        check({nm, "_done_pause"}, 32'(mem_pause), 32'd0);
        if (v.exp_we) check({nm, "_no_rd_en"}, 32'(mem_rd_en), 32'd0);
        else expect_result(nm, v.tag);
        tick();
        check({nm, "_rd_en_once"}, 32'(mem_rd_en), 32'd0);
    endtask

    initial begin
        //                ren   radd          tag    wen   wadd          wdata         dly rdata         exp_addr      be       we    exp_data
        vecs[0]  = '{3'd1, 32'h0000_1003, 7'h15, 3'd0, 32'h0,        32'h0,        0, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 1'b0, 32'hFFFF_FF80};
        vecs[1]  = '{3'd5, 32'h0000_2002, 7'h16, 3'd0, 32'h0,        32'h0,        0, 32'hBEEF_0000, 32'h0000_2000, 4'b1100, 1'b0, 32'h0000_BEEF};
        vecs[2]  = '{3'd3, 32'h0000_3004, 7'h17, 3'd0, 32'h0,        32'h0,        1, 32'hDEAD_BEEF, 32'h0000_3004, 4'b1111, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{3'd2, 32'h0000_2000, 7'h18, 3'd0, 32'h0,        32'h0,        0, 32'h1234_8001, 32'h0000_2000, 4'b0011, 1'b0, 32'hFFFF_8001};
        vecs[4]  = '{3'd4, 32'h0000_1001, 7'h19, 3'd0, 32'h0,        32'h0,        0, 32'h0000_9A00, 32'h0000_1000, 4'b0010, 1'b0, 32'h0000_009A};
        vecs[5]  = '{3'd1, 32'h0000_1002, 7'h1A, 3'd0, 32'h0,        32'h0,        0, 32'h007F_0000, 32'h0000_1000, 4'b0100, 1'b0, 32'h0000_007F};
        vecs[6]  = '{3'd0, 32'h0,         7'h00, 3'd3, 32'h0000_5008, 32'h1122_3344, 1, 32'h0,        32'h0000_5008, 4'b1111, 1'b1, 32'h0};
        vecs[7]  = '{3'd0, 32'h0,         7'h00, 3'd2, 32'h0000_500A, 32'h5566_5566, 0, 32'h0,        32'h0000_5008, 4'b1100, 1'b1, 32'h0};
        vecs[8]  = '{3'd0, 32'h0,         7'h00, 3'd1, 32'h0000_3001, 32'hAAAA_AAAA, 4, 32'h0,        32'h0000_3000, 4'b0010, 1'b1, 32'h0};
        vecs[9]  = '{3'd3, 32'h0000_6000, 7'h2B, 3'd3, 32'h0000_7000, 32'h9999_9999, 2, 32'hCAFE_F00D, 32'h0000_6000, 4'b1111, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{3'd6, 32'h0000_6100, 7'h2C, 3'd1, 32'h0000_7003, 32'h5A5A_5A5A, 0, 32'h0,        32'h0000_7000, 4'b1000, 1'b1, 32'h0};
        vecs[11] = '{3'd5, 32'h0000_4006, 7'h2D, 3'd0, 32'h0,        32'h0,        0, 32'h8001_FFFF, 32'h0000_4004, 4'b1100, 1'b0, 32'h0000_8001};

        reset       = 1'b0;
        pause       = 1'b0;
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        drive_idle();
        #1;
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_pause", 32'(mem_pause), 32'd0);
        check("rst_outs", {dbus_addr[27:0], dbus_be}, 32'h0);
        check("rst_rd", mem_rd_data | 32'(mem_rd_add) | 32'(mem_rd_en) | 32'(mem_err) | 32'(dbus_we), 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table of single transactions on a zero/short-wait bus.
        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reserved encodings and global pause must not start a transaction.
        ex_mem_ren = 3'd7;
        ex_mem_wen = 3'd5;
        #1;
        check("rsvd_pause", 32'(mem_pause), 32'd0);
        tick();
        check("rsvd_req", 32'(dbus_req), 32'd0);
        drive_idle();
        pause       = 1'b1;
        ex_mem_ren  = 3'd3;
        ex_mem_radd = 32'h0000_0100;
        #1;
        check("paused_pause", 32'(mem_pause), 32'd0);
        tick();
        check("paused_req", 32'(dbus_req), 32'd0);
        drive_idle();
        pause = 1'b0;
        tick();

        // LW completing under a 3-cycle pause, then back-to-back LW with gnt+rvalid together.
        ex_mem_ren    = 3'd3;
        ex_mem_radd   = 32'h0000_8000;
        ex_mem_rd_add = 7'h21;
        exp_q.push_back(32'h0123_4567);
        tick();
        drive_idle();
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0123_4567;
        pause       = 1'b1;
        tick();
        dbus_rvalid   = 1'b0;
        ex_mem_ren    = 3'd3;
        ex_mem_radd   = 32'h0000_9000;
        ex_mem_rd_add = 7'h22;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pz_rd_en", 32'(mem_rd_en), 32'd0);
            check("pz_state", 32'(dbg_state), 32'd3);
            check("pz_no_acc", 32'(mem_pause), 32'd0);
            tick();
        end
        pause = 1'b0;
        #1;
        expect_result("pz_res", 7'h21);
        check("pz_resp_no_acc", 32'(mem_pause), 32'd0);
        tick();
        check("pz_next_acc", 32'(mem_pause), 32'd1);
        check("pz_next_rd_en", 32'(mem_rd_en), 32'd0);
        exp_q.push_back(32'h0BAD_F00D);
        tick();
        drive_idle();
        check("ov_addr", dbus_addr, 32'h0000_9000);
        dbus_gnt    = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h0BAD_F00D;
        tick();
        dbus_gnt    = 1'b0;
        dbus_rvalid = 1'b0;
        expect_result("ov_res", 7'h22);
        tick();
        check("ov_rd_en_once", 32'(mem_rd_en), 32'd0);

        // Timeout with TMO_CYCLES=8 and no grant.
        ex_mem_ren    = 3'd1;
        ex_mem_radd   = 32'h0000_A000;
        ex_mem_rd_add = 7'h7F;
        tick();
        drive_idle();
        for (int i = 0; i < 8; i++) begin
            check("tmo_req", 32'(dbus_req), 32'd1);
            check("tmo_err_low", 32'(mem_err), 32'd0);
            tick();
        end
        check("tmo_req_drop", 32'(dbus_req), 32'd0);
        check("tmo_err", 32'(mem_err), 32'd1);
        exp_q.push_back(32'h0);
        expect_result("tmo_res", 7'h7F);
        tick();
        check("tmo_err_pulse", 32'(mem_err), 32'd0);
        check("tmo_rd_en_once", 32'(mem_rd_en), 32'd0);
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        tick();
        dbus_rvalid = 1'b0;
        check("tmo_late_rd_en", 32'(mem_rd_en), 32'd0);
        check("tmo_late_state", 32'(dbg_state), 32'd0);
        tick();

        // Asynchronous reset while in WAIT, then a stray response.
        ex_mem_ren    = 3'd3;
        ex_mem_radd   = 32'h0000_B000;
        ex_mem_rd_add = 7'h44;
        tick();
        drive_idle();
        dbus_gnt = 1'b1;
        tick();
        dbus_gnt = 1'b0;
        check("ar_in_wait", 32'(dbg_state), 32'd2);
        reset = 1'b0;
        #1;
        check("ar_pause", 32'(mem_pause), 32'd0);
        check("ar_addr", dbus_addr, 32'h0);
        check("ar_tag", 32'(mem_rd_add), 32'd0);
        check("ar_state", 32'(dbg_state), 32'd0);
        tick();
        reset = 1'b1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'h1234_5678;
        tick();
        dbus_rvalid = 1'b0;
        check("ar_stray_rd_en", 32'(mem_rd_en), 32'd0);
        check("ar_stray_req", 32'(dbus_req), 32'd0);
        tick();

`ifdef MEM_MISALIGN_CHK_EN
        // Misaligned LW and SH are rejected without touching the bus.
        ex_mem_ren    = 3'd3;
        ex_mem_radd   = 32'h0000_4002;
        ex_mem_rd_add = 7'h33;
        #1;
        check("mis_ld_acc", 32'(mem_pause), 32'd1);
        tick();
        drive_idle();
        check("mis_ld_req", 32'(dbus_req), 32'd0);
        check("mis_ld_err", 32'(mem_err), 32'd1);
        check("mis_ld_pause", 32'(mem_pause), 32'd0);
        exp_q.push_back(32'h0);
        expect_result("mis_ld_res", 7'h33);
        tick();
        check("mis_ld_err_pulse", 32'(mem_err), 32'd0);
        ex_mem_wen   = 3'd2;
        ex_mem_wadd  = 32'h0000_500B;
        ex_mem_wdata = 32'h7777_7777;
        tick();
        drive_idle();
        check("mis_st_req", 32'(dbus_req), 32'd0);
        check("mis_st_err", 32'(mem_err), 32'd1);
        check("mis_st_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
`else
        // Misaligned accesses are truncated to the access size and proceed.
        begin
            vec_t v;
            v = '{3'd3, 32'h0000_4002, 7'h33, 3'd0, 32'h0, 32'h0, 0, 32'h1357_9BDF,
                  32'h0000_4000, 4'b1111, 1'b0, 32'h1357_9BDF};
            run_vec(v, "trunc_lw");
            v = '{3'd2, 32'h0000_2003, 7'h34, 3'd0, 32'h0, 32'h0, 0, 32'hF00D_1234,
                  32'h0000_2000, 4'b1100, 1'b0, 32'hFFFF_F00D};
            run_vec(v, "trunc_lh");
        end
`endif

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps_mem_access.md
Name: ps_mem_access

Overview:
- Data-memory access stage. It is the responder to the execute stage's memory request outputs (ex_mem_ren/radd/rd_add/wen/wadd/wdata).
- Turns each load/store into one transaction on a req/gnt/rvalid data bus, with byte/half/word lanes and sign/zero extension.
- Returns tagged load results toward writeback.
- Stalls the pipeline through mem_pause while a transaction is outstanding.

Parameters:
TMO_CYCLES, 255, cycles spent in REQ+WAIT before a transaction is aborted (1..65535)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pause  in  1  global pipeline stall
ex_mem_ren  in  3  load type: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6/7 treated as 0
ex_mem_radd  in  32  load address
ex_mem_rd_add  in  7  destination tag {rd_tag, rd_add}
ex_mem_wen  in  3  store type: 0 none, 1 SB, 2 SH, 3 SW; 4..7 treated as 0
ex_mem_wadd  in  32  store address
ex_mem_wdata  in  32  store data, already lane-replicated by execute
dbus_req  out  1  bus request
dbus_we  out  1  1 = write
dbus_addr  out  32  word address, low two bits forced to 0
dbus_be  out  4  byte enables
dbus_wdata  out  32  write data
dbus_gnt  in  1  request accepted
dbus_rvalid  in  1  response valid (load data or store ack)
dbus_rdata  in  32  read data
mem_rd_en  out  1  load result valid
mem_rd_add  out  7  load result tag
mem_rd_data  out  32  extended load data
mem_pause  out  1  stall request to pipeline
mem_err  out  1  one-cycle pulse on bus timeout

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, timeout counter=0.
  - All outputs 0: dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, mem_rd_en, mem_rd_add, mem_rd_data, mem_pause, mem_err.
  - Reset mid-transaction drops dbus_req immediately; a later rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, accept:
  - Accept when pause=0 and (ren!=0 or wen!=0).
  - If ren and wen are both nonzero, the load wins and the store is dropped.
  - On accept, latch type, address, tag, wdata and be, then go to REQ.
  - mem_pause is high combinationally in the accept cycle.
  - With pause=1, IDLE accepts nothing.
- Byte enables:
  - byte: 4'b0001 << a[1:0]
  - half: 4'b0011 << {a[1],1'b0}
  - word: 4'hF
- REQ:
  - dbus_req=1; dbus_addr/be/we/wdata are held stable.
  - gnt=1 → WAIT; dbus_req falls the next cycle.
  - rvalid may coincide with gnt. The response is then taken in that same cycle, with the same exits as WAIT.
- WAIT:
  - rvalid with a load: capture the extended data, go to RESP.
  - rvalid with a store: go to IDLE.
- Load extraction:
  - s = dbus_rdata >> (8*a[1:0]).
  - LB sign-extends s[7:0], LBU zero-extends it.
  - LH sign-extends s[15:0], LHU zero-extends it.
  - LW takes s unchanged.
- RESP:
  - mem_rd_en = !pause (combinational); mem_rd_add/mem_rd_data come from registers.
  - Leave to IDLE in the first cycle with pause=0. The result is presented exactly once.
  - No new request is accepted in RESP.
- mem_pause = accept_cycle | state in {REQ, WAIT}.
  - Low in RESP, so the pipeline advances while the result is delivered.
  - A store completes with mem_pause dropping in the cycle after rvalid.
- Latency for a zero-wait bus (gnt and rvalid one cycle apart): load accepted at cycle t gives mem_rd_en at t+3 when pause=0.
- Timeout:
  - The counter clears on accept and increments each cycle in REQ/WAIT.
  - When it reaches TMO_CYCLES: drop dbus_req and pulse mem_err for one cycle.
  - A load then goes to RESP with mem_rd_data=0; a store goes to IDLE.
  - A late rvalid after abort is ignored.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- Defined:
  - A half access with a[0]=1, or a word access with a[1:0]!=0, issues no bus request and pulses mem_err.
  - A misaligned load goes straight to RESP with data 0; a misaligned store returns to IDLE. mem_pause is high only in the accept cycle.
- Undefined: the low address bits are truncated to the access size and the access proceeds aligned; mem_err is timeout-only.

Test Plan:
- LB at 0x1003; bus rdata 0x80FF_1234, gnt/rvalid zero-wait → mem_rd_en=1 at t+3, mem_rd_data=0xFFFF_FF80, mem_rd_add equals the issued tag.
- LHU at 0x2002; rdata 0xBEEF_0000 → mem_rd_data=0x0000_BEEF, dbus_be=4'b1100, dbus_addr=0x2000.
- SB at 0x3001, wdata 0xAAAA_AAAA, gnt delayed 4 cycles → dbus_be=4'b0010 held stable throughout REQ, mem_pause high until the cycle after rvalid, no mem_rd_en.
- LW completes while pause=1 for 3 cycles → mem_rd_en stays 0 in RESP, then high for exactly one cycle after pause falls; a new request is accepted only after that.
- TMO_CYCLES=8, gnt never asserted → dbus_req drops after 8 cycles, mem_err pulses once, load returns data 0, a later rvalid is ignored.
- Async reset asserted in WAIT → all outputs 0 immediately; after release a stray rvalid produces no mem_rd_en. With MEM_MISALIGN_CHK_EN, LW at 0x4002 → no dbus_req, mem_err pulse, mem_rd_data=0.
